// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback/commit stage: the buffered entry,
// the skid FIFO state, EFLAGS bit positions and the architectural EFLAGS reset value.
package wb_pkg;

  typedef enum logic [4:0] {
    CF_BIT = 5'd0,
    PF_BIT = 5'd2,
    AF_BIT = 5'd4,
    ZF_BIT = 5'd6,
    SF_BIT = 5'd7,
    DF_BIT = 5'd10,
    OF_BIT = 5'd11
  } eflags_bit_e;

  localparam logic [31:0] EFLAGS_RESET     = 32'h0000_0002;
  // Reserved bits that always read as zero: 3, 5, 15 and 31:22.
  localparam logic [31:0] EFLAGS_ZERO_MASK = 32'hFFC0_8028;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] flags;
    logic [31:0] mask;
    logic        flags_we;
    logic        reg_we;
    logic [2:0]  dest;
    logic [1:0]  size;
  } wb_entry_t;

  function automatic logic [31:0] merge_eflags(input logic [31:0] cur,
                                               input logic [31:0] flags,
                                               input logic [31:0] mask);
    return (((cur & ~mask) | (flags & mask)) & ~EFLAGS_ZERO_MASK) | EFLAGS_RESET;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order skid FIFO; slot0 is always the head, slot1 holds the second entry
// only in FULL. Flush has priority over push and pop.
module wb_skid_fifo
  import wb_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  wb_entry_t   i_entry,
  output fifo_state_t o_state,
  output wb_entry_t   o_head,
  output wb_entry_t   o_young
);

  fifo_state_t r_state;
  wb_entry_t   r_slot0;
  wb_entry_t   r_slot1;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_EMPTY;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (i_push) begin
            r_slot0 <= i_entry;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (i_push && i_pop) begin
            r_slot0 <= i_entry;
          end else if (i_push) begin
            r_slot1 <= i_entry;
            r_state <= ST_FULL;
          end else if (i_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (i_pop) begin
            r_slot0 <= r_slot1;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_head  = r_slot0;
  assign o_young = (r_state == ST_FULL) ? r_slot1 : r_slot0;

endmodule

// File: rtl/writeback_commit.sv
// Writeback/commit stage: buffers execute results and retires them in order into the
// register-file write port, EFLAGS and a retire counter. Optional: WB_FLAGS_FWD_EN.
module writeback_commit
  import wb_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_flags,
  input  logic [31:0] ex_flags_mask,
  input  logic        ex_flags_we,
  input  logic        ex_reg_we,
  input  logic [2:0]  ex_dest,
  input  logic [1:0]  ex_dest_size,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        wb_reg_we,
  output logic [2:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic [1:0]  wb_reg_size,
  output logic [31:0] eflags,
  output logic        fwd_CF,
  output logic        fwd_AF,
  output logic [31:0] retire_count
);

  fifo_state_t w_state;
  wb_entry_t   w_head;
  wb_entry_t   w_young;
  wb_entry_t   w_in;
  logic        w_push;
  logic        w_pop;
  logic        w_fwd_cf;
  logic        w_fwd_af;

  logic        r_wb_reg_we;
  logic [2:0]  r_wb_reg_addr;
  logic [31:0] r_wb_reg_data;
  logic [1:0]  r_wb_reg_size;
  logic [31:0] r_eflags;
  logic [31:0] r_retire_count;

  assign w_in = '{result:   ex_result,
                  flags:    ex_flags,
                  mask:     ex_flags_mask,
                  flags_we: ex_flags_we,
                  reg_we:   ex_reg_we,
                  dest:     ex_dest,
                  size:     ex_dest_size};

  assign ex_ready = (w_state != ST_FULL);
  assign w_push   = ex_valid && ex_ready && !flush;
  assign w_pop    = (w_state != ST_EMPTY) && !wb_stall && !flush;

  wb_skid_fifo u_fifo (
    .CLK     (CLK),
    .CLR     (CLR),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_entry (w_in),
    .o_state (w_state),
    .o_head  (w_head),
    .o_young (w_young)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_wb_reg_we    <= 1'b0;
      r_wb_reg_addr  <= '0;
      r_wb_reg_data  <= '0;
      r_wb_reg_size  <= '0;
      r_eflags       <= EFLAGS_RESET;
      r_retire_count <= '0;
    end else begin
      r_wb_reg_we <= 1'b0;
      if (w_pop) begin
        r_wb_reg_we    <= w_head.reg_we;
        r_wb_reg_addr  <= w_head.dest;
        r_wb_reg_data  <= w_head.result;
        r_wb_reg_size  <= w_head.size;
        r_retire_count <= r_retire_count + 32'd1;
        if (w_head.flags_we) begin
          r_eflags <= merge_eflags(r_eflags, w_head.flags, w_head.mask);
        end
      end
    end
  end

`ifdef WB_FLAGS_FWD_EN
  // Younger buffered writers override older ones, which override committed EFLAGS.
  always_comb begin
    w_fwd_cf = r_eflags[CF_BIT];
    w_fwd_af = r_eflags[AF_BIT];
    if (w_state == ST_FULL && w_head.flags_we) begin
      if (w_head.mask[CF_BIT]) w_fwd_cf = w_head.flags[CF_BIT];
      if (w_head.mask[AF_BIT]) w_fwd_af = w_head.flags[AF_BIT];
    end
    if (w_state != ST_EMPTY && w_young.flags_we) begin
      if (w_young.mask[CF_BIT]) w_fwd_cf = w_young.flags[CF_BIT];
      if (w_young.mask[AF_BIT]) w_fwd_af = w_young.flags[AF_BIT];
    end
  end
`else
  logic w_unused_young;
  assign w_unused_young = ^w_young;
  assign w_fwd_cf       = r_eflags[CF_BIT];
  assign w_fwd_af       = r_eflags[AF_BIT];
`endif

  assign wb_reg_we    = r_wb_reg_we;
  assign wb_reg_addr  = r_wb_reg_addr;
  assign wb_reg_data  = r_wb_reg_data;
  assign wb_reg_size  = r_wb_reg_size;
  assign eflags       = r_eflags;
  assign retire_count = r_retire_count;
  assign fwd_CF       = w_fwd_cf;
  assign fwd_AF       = w_fwd_af;

endmodule

// File: tb/tb_writeback_commit.sv
// Scoreboard bench for writeback_commit: stimulus pushes expected commits into a queue,
// a negedge monitor pops and compares whenever wb_reg_we is presented.
module tb_writeback_commit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_flags;
  logic [31:0] ex_flags_mask;
  logic        ex_flags_we;
  logic        ex_reg_we;
  logic [2:0]  ex_dest;
  logic [1:0]  ex_dest_size;
  logic        flush;
  logic        wb_stall;
  logic        wb_reg_we;
  logic [2:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic [1:0]  wb_reg_size;
  logic [31:0] eflags;
  logic        fwd_CF;
  logic        fwd_AF;
  logic [31:0] retire_count;

`ifdef WB_FLAGS_FWD_EN
  localparam logic [31:0] FWD_EXP = 32'd1;
`else
  localparam logic [31:0] FWD_EXP = 32'd0;
`endif

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] eflags;
    logic [31:0] count;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_count = 32'd0;

  writeback_commit dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_result     (ex_result),
    .ex_flags      (ex_flags),
    .ex_flags_mask (ex_flags_mask),
    .ex_flags_we   (ex_flags_we),
    .ex_reg_we     (ex_reg_we),
    .ex_dest       (ex_dest),
    .ex_dest_size  (ex_dest_size),
    .flush         (flush),
    .wb_stall      (wb_stall),
    .wb_reg_we     (wb_reg_we),
    .wb_reg_addr   (wb_reg_addr),
    .wb_reg_data   (wb_reg_data),
    .wb_reg_size   (wb_reg_size),
    .eflags        (eflags),
    .fwd_CF        (fwd_CF),
    .fwd_AF        (fwd_AF),
    .retire_count  (retire_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Drives one entry; track=1 means it is expected to commit with the given EFLAGS.
  task automatic send(input logic [31:0] res, input logic [2:0] dest, input logic [1:0] sz,
                      input logic [31:0] fl, input logic [31:0] mk, input logic fwe,
                      input logic [31:0] exp_ef, input bit track);
    int n = 0;
    @(negedge CLK);
    ex_valid      = 1'b1;
    ex_result     = res;
    ex_dest       = dest;
    ex_dest_size  = sz;
    ex_flags      = fl;
    ex_flags_mask = mk;
    ex_flags_we   = fwe;
    ex_reg_we     = 1'b1;
    while (!ex_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!ex_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=ready_low required=ready_high data=%h", res);
      ex_valid = 1'b0;
      return;
    end
    if (track) begin
      m_count = m_count + 32'd1;
      sb_q.push_back('{dest, res, sz, exp_ef, m_count});
    end
    @(posedge CLK);
    #1 ex_valid = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!CLR && wb_reg_we) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit actual=addr%0d/%h required=no_commit", wb_reg_addr, wb_reg_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("commit_addr",   32'(wb_reg_addr), 32'(mon_e.addr));
        chk("commit_data",   wb_reg_data,      mon_e.data);
        chk("commit_size",   32'(wb_reg_size), 32'(mon_e.size));
        chk("commit_eflags", eflags,           mon_e.eflags);
        chk("commit_count",  retire_count,     mon_e.count);
      end
    end
  end

  initial begin
    int n;
    CLR = 1'b1;
    ex_valid = 1'b0; ex_result = '0; ex_flags = '0; ex_flags_mask = '0;
    ex_flags_we = 1'b0; ex_reg_we = 1'b0; ex_dest = '0; ex_dest_size = '0;
    flush = 1'b0; wb_stall = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready",  32'(ex_ready),    32'd1);
    chk("rst_we",     32'(wb_reg_we),   32'd0);
    chk("rst_addr",   32'(wb_reg_addr), 32'd0);
    chk("rst_data",   wb_reg_data,      32'd0);
    chk("rst_size",   32'(wb_reg_size), 32'd0);
    chk("rst_eflags", eflags,           32'h0000_0002);
    chk("rst_count",  retire_count,     32'd0);
    CLR = 1'b0;

    // Single entry with latency check.
    send(32'h0000_1234, 3'd3, 2'd2, 32'h0, 32'h0, 1'b0, 32'h0000_0002, 1'b1);
    @(negedge CLK); chk("lat_cycle1_we", 32'(wb_reg_we), 32'd0);
    @(negedge CLK); chk("lat_cycle2_we", 32'(wb_reg_we), 32'd1);

    // Flag merge patterns, back to back.
    send(32'hAAAA_5555, 3'd5, 2'd0, 32'h0000_0FFF, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b1);
    send(32'h0000_0000, 3'd0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h003F_7FD7, 1'b1);
    send(32'h0000_0007, 3'd7, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h003F_7FD7, 1'b1);
    send(32'hDEAD_BEEF, 3'd1, 2'd2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002, 1'b1);
    send(32'h0000_0055, 3'd2, 2'd0, 32'h0000_08C4, 32'h0000_0CD5, 1'b1, 32'h0000_08C6, 1'b1);
    repeat (3) @(negedge CLK);

    // Forwarding of a buffered CF/AF writer while stalled.
    wb_stall = 1'b1;
    send(32'h0000_0066, 3'd4, 2'd2, 32'h0000_0011, 32'h0000_0011, 1'b1, 32'h0000_08D7, 1'b1);
    @(negedge CLK);
    chk("fwd_cf_buffered", 32'(fwd_CF), FWD_EXP);
    chk("fwd_af_buffered", 32'(fwd_AF), FWD_EXP);
    chk("stall_eflags",    eflags,      32'h0000_08C6);
    chk("stall_count",     retire_count, m_count - 32'd1);
    wb_stall = 1'b0;
    repeat (3) @(negedge CLK);
    chk("fwd_cf_committed", 32'(fwd_CF), 32'd1);

    // Three entries into a stalled two-entry buffer, then consecutive drain.
    wb_stall = 1'b1;
    fork
      begin
        send(32'h1111_0001, 3'd1, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0000_08D7, 1'b1);
        send(32'h2222_0002, 3'd2, 2'd1, 32'h0, 32'h0, 1'b0, 32'h0000_08D7, 1'b1);
        send(32'h3333_0003, 3'd6, 2'd2, 32'h0, 32'h0, 1'b0, 32'h0000_08D7, 1'b1);
      end
      begin
        repeat (3) @(negedge CLK);
        chk("full_ready_low", 32'(ex_ready), 32'd0);
        wb_stall = 1'b0;
        repeat (3) @(negedge CLK);
        #2 chk("consecutive_drain_left", 32'(sb_q.size()), 32'd0);
      end
    join
    repeat (2) @(negedge CLK);

    // Flush with two entries buffered.
    wb_stall = 1'b1;
    send(32'hBAD0_0001, 3'd3, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    send(32'hBAD0_0002, 3'd4, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    @(negedge CLK);
    chk("flush_pre_ready", 32'(ex_ready), 32'd0);
    flush = 1'b1;
    ex_valid = 1'b1;
    ex_result = 32'hBAD0_0003;
    @(posedge CLK);
    #1 flush = 1'b0; ex_valid = 1'b0; wb_stall = 1'b0;
    @(negedge CLK);
    chk("flush_empty_ready", 32'(ex_ready),  32'd1);
    chk("flush_no_we",       32'(wb_reg_we), 32'd0);
    chk("flush_eflags",      eflags,         32'h0000_08D7);
    chk("flush_count",       retire_count,   m_count);
    repeat (3) @(negedge CLK);
    chk("flush_later_count", retire_count,   m_count);

    // Retire counter wrap.
    @(negedge CLK);
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1 release dut.r_retire_count;
    m_count = 32'hFFFF_FFFF;
    send(32'hCAFE_F00D, 3'd5, 2'd1, 32'h0, 32'h0, 1'b0, 32'h0000_08D7, 1'b1);
    repeat (3) @(negedge CLK);
    chk("wrap_count", retire_count, 32'd0);

    // Asynchronous reset while entries sit stalled.
    wb_stall = 1'b1;
    send(32'hBAD1_0001, 3'd1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    send(32'hBAD1_0002, 3'd2, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    @(negedge CLK);
    #1 CLR = 1'b1;
    #1;
    chk("aclr_ready",  32'(ex_ready),    32'd1);
    chk("aclr_we",     32'(wb_reg_we),   32'd0);
    chk("aclr_addr",   32'(wb_reg_addr), 32'd0);
    chk("aclr_data",   wb_reg_data,      32'd0);
    chk("aclr_size",   32'(wb_reg_size), 32'd0);
    chk("aclr_eflags", eflags,           32'h0000_0002);
    chk("aclr_count",  retire_count,     32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    wb_stall = 1'b0;
    m_count = 32'd0;
    repeat (4) @(negedge CLK);
    chk("aclr_lost_count",  retire_count, 32'd0);
    chk("aclr_lost_eflags", eflags,       32'h0000_0002);

    // One transaction after reset to confirm normal operation resumes.
    send(32'h0BAD_F00D, 3'd2, 2'd0, 32'h0000_0800, 32'h0000_0800, 1'b1, 32'h0000_0802, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    #2 chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_commit.md
WRITEBACK_COMMIT -- requirements
Module: writeback_commit

Interface
REQ-001 SHALL: CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: CLR  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: ex_valid  input  1  execute stage presents a result this cycle.
REQ-004 SHALL: ex_ready  output  1  block accepts the result this cycle.
REQ-005 SHALL: ex_result  input  32  ALU or shifter result.
REQ-006 SHALL: ex_flags  input  32  flags produced by execute (CF=0, PF=2, AF=4, ZF=6, SF=7, DF=10, OF=11).
REQ-007 SHALL: ex_flags_mask  input  32  per-bit select of the flags the instruction updates.
REQ-008 SHALL: ex_flags_we, ex_reg_we  input  1 each  flag-update enable and register-write enable.
REQ-009 SHALL: ex_dest  input  3  destination GPR; ex_dest_size  input  2  byte=0, word=1, dword=2.
REQ-010 SHALL: flush  input  1  discards all uncommitted entries.
REQ-011 SHALL: wb_stall  input  1  register-file port busy; no commit while high.
REQ-012 SHALL: wb_reg_we  output  1 / wb_reg_addr  output  3 / wb_reg_data  output  32 / wb_reg_size  output  2  registered register-file write port.
REQ-013 SHALL: eflags  output  32  architectural EFLAGS.
REQ-014 SHALL: fwd_CF, fwd_AF  output  1 each  carry and auxiliary flags forwarded to execute (DAA, ADC).
REQ-015 SHALL: retire_count  output  32  number of committed entries.

Function
REQ-016 SHALL: buffer entries in a 2-entry in-order skid FIFO with states EMPTY, ONE, FULL.
REQ-017 SHALL: drive ex_ready = (state != FULL), decoded from registered state only.
REQ-018 SHALL: push on ex_valid && ex_ready && !flush.
REQ-019 SHALL: pop the head when state != EMPTY && !wb_stall && !flush.
REQ-020 SHALL: on a simultaneous push and pop in ONE, remain in ONE.
REQ-021 SHALL: when FULL with a pop, go to ONE (no push, since ready=0).
REQ-022 SHALL: on pop, register wb_reg_we=head.reg_we, wb_reg_addr, wb_reg_data, wb_reg_size from the head; in every other cycle wb_reg_we=0 and the other write-port outputs hold their values.
REQ-023 SHALL: on pop with head.flags_we=1, set eflags <= (eflags & ~mask) | (flags & mask), with bit 1 forced to 1 and bits 3, 5, 15 and 31:22 forced to 0.
REQ-024 SHALL: on every pop, increment retire_count by 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-025 SHALL: accept in cycle N and produce wb_reg_we/eflags visible in cycle N+2 when wb_stall=0 (latency 2).
REQ-026 SHALL: on flush, go to EMPTY; the same-cycle ex input and head are discarded, eflags and retire_count are unchanged, and wb_reg_we=0 next cycle.

Reset
REQ-027 SHALL: while CLR is high, immediately set state=EMPTY, eflags=32'h0000_0002, retire_count=0, wb_reg_we=0, wb_reg_addr=0, wb_reg_data=0, wb_reg_size=0.
REQ-028 SHALL: lose all buffered entries, with no commit, when CLR asserts mid-operation.

Configuration
REQ-029 SHALL: when WB_FLAGS_FWD_EN is defined, drive fwd_CF/fwd_AF from the youngest buffered entry with flags_we=1 and the corresponding mask bit (0 or 4) set, else from eflags.
REQ-030 SHALL: when WB_FLAGS_FWD_EN is undefined, drive fwd_CF=eflags[0] and fwd_AF=eflags[4] only.

Structure
REQ-031 SHALL: place the entry struct, FIFO state enum, EFLAGS bit-position constants and the reset value 32'h0000_0002 in shared package wb_pkg.
REQ-032 SHALL: implement the FIFO as sub-module wb_skid_fifo (push/pop/flush, head and youngest-entry outputs); commit, EFLAGS and the counter live in writeback_commit.

Verification
REQ-033 SHALL: push result=32'h1234, dest=3, reg_we=1, stall=0 -> wb_reg_we=1, addr=3, data=32'h1234 two cycles later; retire_count=1.
REQ-034 SHALL: with eflags=32'h0000_0002, push flags=32'h0000_0FFF, mask=32'h0000_0001 -> eflags=32'h0000_0003.
REQ-035 SHALL: hold wb_stall=1 and push 3 back-to-back entries -> ex_ready=0 after 2 pushes; release stall -> all 3 commit in order on consecutive cycles.
REQ-036 SHALL: with WB_FLAGS_FWD_EN, buffer an entry with CF mask set and flags[0]=1 while stalled -> fwd_CF=1 while eflags[0]=0; without the macro -> fwd_CF=0.
REQ-037 SHALL: with 2 entries buffered, assert flush -> state EMPTY next cycle, no wb_reg_we, eflags and retire_count unchanged.
REQ-038 SHALL: preload retire_count=32'hFFFF_FFFF, commit one entry -> retire_count=0; assert CLR mid-stall -> all outputs return to reset values without a clock edge.
